// File: rtl/rom_loader_if.sv
// Byte-stream in / word-write out bundle for the program ROM loader.
// The slave modport is the loader; the master modport is the host/array side.
interface rom_loader_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  start_i;
    logic [7:0]            byte_data_i;
    logic                  byte_valid_i;
    logic                  byte_ready_o;
    logic                  wr_en_o;
    logic                  wr_ready_i;
    logic [ADDR_WIDTH-2:0] wr_addr_o;
    logic [15:0]           wr_data_o;
    logic                  busy_o;
    logic                  done_o;
    logic [ADDR_WIDTH:0]   byte_count_o;
    logic [15:0]           checksum_o;

    modport slave (
        input  start_i, byte_data_i, byte_valid_i, wr_ready_i,
        output byte_ready_o, wr_en_o, wr_addr_o, wr_data_o,
        output busy_o, done_o, byte_count_o, checksum_o
    );

    modport master (
        output start_i, byte_data_i, byte_valid_i, wr_ready_i,
        input  byte_ready_o, wr_en_o, wr_addr_o, wr_data_o,
        input  busy_o, done_o, byte_count_o, checksum_o
    );
endinterface

// File: rtl/rom_loader.sv
// Pairs an ascending byte stream into 16-bit ROM words and issues word writes,
// tracking byte count and a running byte checksum until the image is resident.
module rom_loader #(
    parameter int ADDR_WIDTH = 16
) (
    input logic         clock_i,
    input logic         reset_n_i,
    rom_loader_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_all_taken;
    logic [7:0]            r_low;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-2:0] r_wr_addr;
    logic [15:0]           r_wr_data;
    logic [ADDR_WIDTH:0]   r_count;
    logic [15:0]           r_sum;

    logic w_byte_ready;
    logic w_byte_hs;
    logic w_wr_hs;

    // A stalled write blocks new bytes, but a completing write does not.
    assign w_byte_ready = (r_state == S_LOAD) & ~(r_wr_en & ~bus.wr_ready_i) & ~r_all_taken;
    assign w_byte_hs    = bus.byte_valid_i & w_byte_ready;
    assign w_wr_hs      = r_wr_en & bus.wr_ready_i;

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_all_taken <= 1'b0;
            r_low       <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_count     <= '0;
            r_sum       <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start_i) begin
                        r_state     <= S_LOAD;
                        r_addr      <= '0;
                        r_all_taken <= 1'b0;
                        r_wr_en     <= 1'b0;
                        r_count     <= '0;
                        r_sum       <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_byte_hs) begin
                        r_count <= r_count + 1'b1;
                        r_sum   <= r_sum + {8'd0, bus.byte_data_i};
                        // Last byte pins the address instead of wrapping.
                        if (&r_addr) r_all_taken <= 1'b1;
                        else         r_addr      <= r_addr + 1'b1;
                        if (r_addr[0]) begin
                            r_wr_data <= {bus.byte_data_i, r_low};
                            r_wr_addr <= r_addr[ADDR_WIDTH-1:1];
                        end else begin
                            r_low <= bus.byte_data_i;
                        end
                    end
                    if (w_byte_hs && r_addr[0]) r_wr_en <= 1'b1;
                    else if (w_wr_hs)           r_wr_en <= 1'b0;
                    if (w_wr_hs && r_all_taken) r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.byte_ready_o = w_byte_ready;
    assign bus.wr_en_o      = r_wr_en;
    assign bus.wr_addr_o    = r_wr_addr;
    assign bus.wr_data_o    = r_wr_data;
    assign bus.busy_o       = (r_state == S_LOAD);
    assign bus.done_o       = (r_state == S_DONE);
    assign bus.byte_count_o = r_count;
    assign bus.checksum_o   = r_sum;
endmodule
